// File: rtl/h6_mul_seq.sv
// h6_mul_seq: 16x16 unsigned radix-2 shift-add multiplier, 16 RUN cycles.
// Ports:
//   clk, rst (sync, active-high); start, multiplicand, multiplier in;
//   H6_a_out (product high half), H6_q_out (product low half), busy, done out.
module h6_mul_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  output logic [15:0] H6_a_out,
  output logic [15:0] H6_q_out,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        c_q, c_d;
  logic [15:0] a_q, a_d;
  logic [15:0] q_q, q_d;
  logic [15:0] m_q, m_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [16:0] sum;

  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    cnt_d   = cnt_q;
    // {C,A} for this iteration, before the shift
    sum     = q_q[0] ? ({1'b0, a_q} + {1'b0, m_q})
                     : {1'b0, a_q};
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d     = multiplicand;
          q_d     = multiplier;
          a_d     = '0;
          c_d     = 1'b0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // {C,A,Q} <= {0,C,A,Q} >> 1: carry drops into A[15],
        // A[0] drops into Q[15], C is always cleared.
        c_d   = 1'b0;
        a_d   = sum[16:1];
        q_d   = {sum[0], q_q[15:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      c_q     <= 1'b0;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign H6_a_out = a_q;
  assign H6_q_out = q_q;

endmodule

// File: tb/tb_h6_mul_seq.sv
// tb_h6_mul_seq: scoreboard bench for h6_mul_seq.
// Inputs driven and outputs sampled on the falling edge.
module tb_h6_mul_seq;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [15:0] H6_a_out;
  logic [15:0] H6_q_out;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb[$];

  h6_mul_seq dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .H6_a_out     (H6_a_out),
    .H6_q_out     (H6_q_out),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ref_mul(input logic [15:0] m,
                                          input logic [15:0] q);
    logic [31:0] mm;
    logic [31:0] qq;
    mm = {16'h0, m};
    qq = {16'h0, q};
    return mm * qq;
  endfunction

  task automatic start_mul(input logic [15:0] m, input logic [15:0] q);
    @(negedge clk);
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    sb.push_back(ref_mul(m, q));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = 0;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy === 1'b1) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst          = 1'b1;
    start        = 1'b1;
    multiplicand = 16'h1111;
    multiplier   = 16'h2222;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (H6_a_out !== 16'h0) begin
      n_err++;
      $display("FAIL reset_a: got %h expected 0000", H6_a_out);
    end
    n_cmp++;
    if (H6_q_out !== 16'h0) begin
      n_err++;
      $display("FAIL reset_q: got %h expected 0000", H6_q_out);
    end
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: got busy=%b done=%b expected 0 0",
               busy, done);
    end
    start = 1'b0;
    rst   = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int cyc, bcnt;
    logic [31:0] exp;
    start_mul(16'h0003, 16'h0005);
    multiplicand = 16'hFFFF;
    multiplier   = 16'hAAAA;
    wait_done(cyc, bcnt);
    exp = sb.pop_front();
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL basic_done: got %b expected 1", done);
    end
    n_cmp++;
    if (bcnt != 16) begin
      n_err++;
      $display("FAIL basic_busy_cycles: got %0d expected 16", bcnt);
    end
    n_cmp++;
    if ({H6_a_out, H6_q_out} !== exp) begin
      n_err++;
      $display("FAIL basic_result: got %h expected %h",
               {H6_a_out, H6_q_out}, exp);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_pulse: got %b expected 0", done);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({H6_a_out, H6_q_out} !== exp) begin
      n_err++;
      $display("FAIL basic_hold: got %h expected %h",
               {H6_a_out, H6_q_out}, exp);
    end
  endtask

  task automatic test_max;
    int cyc, bcnt;
    logic [31:0] exp;
    logic [15:0] ma [2];
    logic [15:0] qa [2];
    ma[0] = 16'hFFFF; qa[0] = 16'hFFFF;
    ma[1] = 16'h8000; qa[1] = 16'h0002;
    for (int i = 0; i < 2; i++) begin
      start_mul(ma[i], qa[i]);
      wait_done(cyc, bcnt);
      exp = sb.pop_front();
      n_cmp++;
      if (done !== 1'b1 || {H6_a_out, H6_q_out} !== exp) begin
        n_err++;
        $display("FAIL max_%0d: got done=%b %h expected 1 %h",
                 i, done, {H6_a_out, H6_q_out}, exp);
      end
    end
  endtask

  task automatic test_zero;
    int cyc, bcnt;
    logic [31:0] exp;
    start_mul(16'h0000, 16'h1234);
    wait_done(cyc, bcnt);
    exp = sb.pop_front();
    n_cmp++;
    if (cyc != 16 || done !== 1'b1) begin
      n_err++;
      $display("FAIL zero_latency: got %0d expected 16", cyc);
    end
    n_cmp++;
    if ({H6_a_out, H6_q_out} !== exp) begin
      n_err++;
      $display("FAIL zero_result: got %h expected %h",
               {H6_a_out, H6_q_out}, exp);
    end
  endtask

  task automatic test_start_while_busy;
    int cyc, bcnt, ndone;
    logic [31:0] exp;
    start_mul(16'h1234, 16'h0056);
    repeat (4) @(negedge clk);
    start        = 1'b1;
    multiplicand = 16'h7777;
    multiplier   = 16'h3333;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc, bcnt);
    exp = sb.pop_front();
    n_cmp++;
    if (done !== 1'b1 || {H6_a_out, H6_q_out} !== exp) begin
      n_err++;
      $display("FAIL busy_start: got done=%b %h expected 1 %h",
               done, {H6_a_out, H6_q_out}, exp);
    end
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_err++;
      $display("FAIL busy_extra_done: got %0d expected 0", ndone);
    end
  endtask

  task automatic test_reset_mid;
    int cyc, bcnt, ndone;
    logic [31:0] exp;
    start_mul(16'hABCD, 16'h1357);
    void'(sb.pop_back());
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({H6_a_out, H6_q_out} !== 32'h0 || busy !== 1'b0 ||
        done !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: got %h b=%b d=%b expected 0 0 0",
               {H6_a_out, H6_q_out}, busy, done);
    end
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    n_cmp++;
    if (ndone != 0) begin
      n_err++;
      $display("FAIL mid_no_done: got %0d expected 0", ndone);
    end
    start_mul(16'h0007, 16'h0009);
    wait_done(cyc, bcnt);
    exp = sb.pop_front();
    n_cmp++;
    if (done !== 1'b1 || {H6_a_out, H6_q_out} !== exp) begin
      n_err++;
      $display("FAIL mid_after: got done=%b %h expected 1 %h",
               done, {H6_a_out, H6_q_out}, exp);
    end
  endtask

  task automatic test_back_to_back(input int n, input bit rnd);
    int cyc, bcnt, want;
    logic [31:0] exp;
    logic [15:0] m, q;
    logic [15:0] tm [4];
    logic [15:0] tq [4];
    tm[0] = 16'h0003; tq[0] = 16'h0005;
    tm[1] = 16'hFFFF; tq[1] = 16'hFFFF;
    tm[2] = 16'h1234; tq[2] = 16'h5678;
    tm[3] = 16'h8000; tq[3] = 16'h8000;
    @(negedge clk);
    m = rnd ? 16'($urandom) : tm[0];
    q = rnd ? 16'($urandom) : tq[0];
    start        = 1'b1;
    multiplicand = m;
    multiplier   = q;
    sb.push_back(ref_mul(m, q));
    @(negedge clk);
    want = 16;
    for (int i = 0; i < n; i++) begin
      wait_done(cyc, bcnt);
      exp = sb.pop_front();
      n_cmp++;
      if (done !== 1'b1 || cyc != want) begin
        n_err++;
        $display("FAIL b2b_period_%0d: got done=%b cyc=%0d expected 1 %0d",
                 i, done, cyc, want);
      end
      n_cmp++;
      if ({H6_a_out, H6_q_out} !== exp) begin
        n_err++;
        $display("FAIL b2b_result_%0d: got %h expected %h",
                 i, {H6_a_out, H6_q_out}, exp);
      end
      if (i < n - 1) begin
        m = rnd ? 16'($urandom) : tm[(i + 1) % 4];
        q = rnd ? 16'($urandom) : tq[(i + 1) % 4];
        multiplicand = m;
        multiplier   = q;
        sb.push_back(ref_mul(m, q));
        @(negedge clk);
        want = 17;
      end else begin
        start = 1'b0;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = 16'h0;
    multiplier   = 16'h0;
    test_reset;
    test_basic;
    test_max;
    test_zero;
    test_start_while_busy;
    test_reset_mid;
    test_back_to_back(6, 1'b0);
    test_back_to_back(1000, 1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
